// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, state encoding and IR field positions for the sequencer
package proc_pkg;

    // Opcode field values of IR[8:6]
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    // Bit positions of the IR fields
    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_X_HI  = 5;
    localparam int IR_X_LO  = 3;
    localparam int IR_Y_HI  = 2;
    localparam int IR_Y_LO  = 0;

    // Fetch states F0..F2, execute states T1..T3
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_F2   = 3'd3,
        ST_T1   = 3'd4,
        ST_T2   = 3'd5,
        ST_T3   = 3'd6
    } state_t;

    // Instructions whose T2 cycle waits on memory data
    function automatic logic op_waits_mem(input logic [2:0] op);
        return (op == OP_MVI) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// rtl/proc_sequencer_if.sv - control/handshake bundle between sequencer and datapath/memory
interface proc_sequencer_if;

    logic       run;
    logic [8:0] ir;
    logic       g_nz;
    logic       mem_ready;

    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       din_out;
    logic       add_sub;
    logic       ir_in;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic       incr_pc;
    logic       done;
    logic       mem_err;

    // Sequencer side
    modport master (
        input  run, ir, g_nz, mem_ready,
        output r_in, r_out, a_in, g_in, g_out, din_out, add_sub,
               ir_in, addr_in, dout_in, w_d, incr_pc, done, mem_err
    );

    // Datapath / memory side
    modport slave (
        output run, ir, g_nz, mem_ready,
        input  r_in, r_out, a_in, g_in, g_out, din_out, add_sub,
               ir_in, addr_in, dout_in, w_d, incr_pc, done, mem_err
    );

endinterface

// File: rtl/reg_decoder.sv
// rtl/reg_decoder.sv - 3-to-8 one-hot register select with enable
module reg_decoder (
    input  logic [2:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_onehot
);

    // One-hot decode; all zeros when disabled
    always_comb begin
        o_onehot = 8'h00;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - fetch/decode/execute control sequencer for the 9-bit bus processor
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    proc_sequencer_if.master  bus
);

    localparam int CW = ($clog2(WAIT_MAX + 1) < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;

    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_x_oh;
    logic [7:0] w_y_oh;

    logic w_rin_x;
    logic w_rout_x;
    logic w_rout_y;
    logic w_rout_pc;
    logic w_a_in;
    logic w_g_in;
    logic w_g_out;
    logic w_din_out;
    logic w_add_sub;
    logic w_ir_in;
    logic w_addr_in;
    logic w_dout_in;
    logic w_w_d;
    logic w_incr_pc;
    logic w_done;
    logic w_waiting;
    logic w_timeout;

    assign w_op = bus.ir[IR_OP_HI:IR_OP_LO];
    assign w_x  = bus.ir[IR_X_HI:IR_X_LO];
    assign w_y  = bus.ir[IR_Y_HI:IR_Y_LO];

    // A memory wait is in progress in F1 always, and in T2 only for mvi/ld
    assign w_waiting = (r_state == ST_F1) ||
                       ((r_state == ST_T2) && op_waits_mem(w_op));
    assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == WAIT_LIMIT);

    // X decoder feeds both load enables and bus drive; Y only drives the bus
    reg_decoder u_dec_x (
        .i_sel    (w_x),
        .i_en     (w_rin_x | w_rout_x),
        .o_onehot (w_x_oh)
    );

    reg_decoder u_dec_y (
        .i_sel    (w_y),
        .i_en     (w_rout_y),
        .o_onehot (w_y_oh)
    );

    // Per-state control decode from registered state, IR and G flag
    always_comb begin
        w_rin_x   = 1'b0;
        w_rout_x  = 1'b0;
        w_rout_y  = 1'b0;
        w_rout_pc = 1'b0;
        w_a_in    = 1'b0;
        w_g_in    = 1'b0;
        w_g_out   = 1'b0;
        w_din_out = 1'b0;
        w_add_sub = 1'b0;
        w_ir_in   = 1'b0;
        w_addr_in = 1'b0;
        w_dout_in = 1'b0;
        w_w_d     = 1'b0;
        w_incr_pc = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_F0: begin
                w_rout_pc = 1'b1;
                w_addr_in = 1'b1;
                w_incr_pc = 1'b1;
            end
            ST_F2: begin
                w_din_out = 1'b1;
                w_ir_in   = 1'b1;
            end
            ST_T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout_y = 1'b1;
                        w_rin_x  = 1'b1;
                        w_done   = 1'b1;
                    end
                    OP_MVI: begin
                        w_rout_pc = 1'b1;
                        w_addr_in = 1'b1;
                        w_incr_pc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_x = 1'b1;
                        w_a_in   = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        w_rout_y  = 1'b1;
                        w_addr_in = 1'b1;
                    end
                    OP_MVNZ: begin
                        w_done   = 1'b1;
                        w_rout_y = bus.g_nz;
                        w_rin_x  = bus.g_nz;
                    end
                    OP_NOP: begin
                        w_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T2: begin
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        w_rout_y  = 1'b1;
                        w_g_in    = 1'b1;
                        w_add_sub = w_op[0];
                    end
                    OP_ST: begin
                        w_rout_x  = 1'b1;
                        w_dout_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T3: begin
                w_done = 1'b1;
                case (w_op)
                    OP_MVI, OP_LD: begin
                        w_din_out = 1'b1;
                        w_rin_x   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_g_out = 1'b1;
                        w_rin_x = 1'b1;
                    end
                    OP_ST: begin
                        w_w_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Sequencer state machine with memory-wait timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.run) begin
                        r_state <= ST_F0;
                    end
                end
                ST_F0: begin
                    r_state    <= ST_F1;
                    r_wait_cnt <= '0;
                end
                ST_F1: begin
                    if (bus.mem_ready) begin
                        r_state <= ST_F2;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                ST_F2: begin
                    r_state <= ST_T1;
                end
                ST_T1: begin
                    if (w_done) begin
                        r_state <= bus.run ? ST_F0 : ST_IDLE;
                    end else begin
                        r_state    <= ST_T2;
                        r_wait_cnt <= '0;
                    end
                end
                ST_T2: begin
                    if (!op_waits_mem(w_op) || bus.mem_ready) begin
                        r_state <= ST_T3;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                ST_T3: begin
                    r_state <= bus.run ? ST_F0 : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // PC (R7) select used during fetch and mvi is merged with the decoded selects
    assign bus.r_in    = w_x_oh & {8{w_rin_x}};
    assign bus.r_out   = w_y_oh | (w_x_oh & {8{w_rout_x}}) | (w_rout_pc ? 8'h80 : 8'h00);
    assign bus.a_in    = w_a_in;
    assign bus.g_in    = w_g_in;
    assign bus.g_out   = w_g_out;
    assign bus.din_out = w_din_out;
    assign bus.add_sub = w_add_sub;
    assign bus.ir_in   = w_ir_in;
    assign bus.addr_in = w_addr_in;
    assign bus.dout_in = w_dout_in;
    assign bus.w_d     = w_w_d;
    assign bus.incr_pc = w_incr_pc;
    assign bus.done    = w_done;
    assign bus.mem_err = w_timeout;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - self-checking bench for proc_sequencer
module tb_proc_sequencer;

    localparam logic [11:0] F_AIN    = 12'h800;
    localparam logic [11:0] F_GIN    = 12'h400;
    localparam logic [11:0] F_GOUT   = 12'h200;
    localparam logic [11:0] F_DIN    = 12'h100;
    localparam logic [11:0] F_ADDSUB = 12'h080;
    localparam logic [11:0] F_IRIN   = 12'h040;
    localparam logic [11:0] F_ADDR   = 12'h020;
    localparam logic [11:0] F_DOUT   = 12'h010;
    localparam logic [11:0] F_WD     = 12'h008;
    localparam logic [11:0] F_INC    = 12'h004;
    localparam logic [11:0] F_DONE   = 12'h002;
    localparam logic [11:0] F_MERR   = 12'h001;

    localparam logic [27:0] W_F0 = {8'h00, 8'h80, 12'h024};
    localparam logic [27:0] W_F2 = {8'h00, 8'h00, 12'h140};

    typedef struct {
        logic [27:0] exp;
        logic        run;
        logic        mrdy;
        logic        gnz;
        logic [8:0]  ir;
        bit          first;
        bit          last;
        int          lat;
        string       tag;
    } entry_t;

    typedef struct {
        string       tag;
        logic [8:0]  ins;
        logic        gnz;
        int          lat;
        logic [27:0] t1;
        logic [27:0] t2;
        logic [27:0] t3;
    } vec_t;

    logic clock;
    logic reset;
    logic [27:0] act;
    logic [8:0]  last_ir;
    int n_cmp;
    int n_bad;
    entry_t q[$];
    vec_t   vecs[10];

    proc_sequencer_if bus ();

    proc_sequencer #(.WAIT_MAX(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign act = {bus.r_in, bus.r_out, bus.a_in, bus.g_in, bus.g_out, bus.din_out,
                  bus.add_sub, bus.ir_in, bus.addr_in, bus.dout_in, bus.w_d,
                  bus.incr_pc, bus.done, bus.mem_err};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Bus one-driver rule checked every cycle, away from both edges
    always @(negedge clock) begin
        #2;
        n_cmp++;
        assert ($countones({bus.r_out, bus.g_out, bus.din_out}) <= 1)
        else begin
            n_bad++;
            $display("FAIL bus_one_driver: drivers=%0d allowed<=1 r_out=%h",
                     $countones({bus.r_out, bus.g_out, bus.din_out}), bus.r_out);
        end
    end

    function automatic logic [27:0] mk(input logic [7:0] rin, input logic [7:0] rout,
                                       input logic [11:0] f);
        return {rin, rout, f};
    endfunction

    task automatic chk_word(input string tag, input logic [27:0] got, input logic [27:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got r_in=%h r_out=%h flags=%h want r_in=%h r_out=%h flags=%h",
                     tag, got[27:20], got[19:12], got[11:0], want[27:20], want[19:12], want[11:0]);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic push(input logic [27:0] exp, input logic run, input logic mrdy,
                        input logic gnz, input logic [8:0] ir, input bit first,
                        input bit last, input int lat, input string tag);
        entry_t e;
        e.exp = exp; e.run = run; e.mrdy = mrdy; e.gnz = gnz; e.ir = ir;
        e.first = first; e.last = last; e.lat = lat; e.tag = tag;
        q.push_back(e);
    endtask

    // Plan one instruction: fetch with f1w wait cycles, then nt execute cycles
    task automatic push_instr(input string tag, input logic [8:0] ins, input logic gnz,
                              input int f1w, input int t2w, input int nt,
                              input logic [27:0] t1, input logic [27:0] t2,
                              input logic [27:0] t3, input int lat,
                              input logic run_mid, input logic run_end);
        push(W_F0, run_mid, 1'b0, gnz, last_ir, 1, 0, lat, {tag, "_f0"});
        for (int i = 0; i < f1w; i++)
            push(28'h0, run_mid, 1'b0, gnz, last_ir, 0, 0, lat, {tag, "_f1wait"});
        push(28'h0, run_mid, 1'b1, gnz, last_ir, 0, 0, lat, {tag, "_f1"});
        push(W_F2, run_mid, 1'b1, gnz, last_ir, 0, 0, lat, {tag, "_f2"});
        push(t1, (nt == 1) ? run_end : run_mid, 1'b1, gnz, ins, 0, nt == 1, lat, {tag, "_t1"});
        if (nt == 3) begin
            for (int i = 0; i < t2w; i++)
                push(28'h0, run_mid, 1'b0, gnz, ins, 0, 0, lat, {tag, "_t2wait"});
            push(t2, run_mid, 1'b1, gnz, ins, 0, 0, lat, {tag, "_t2"});
            push(t3, run_end, 1'b1, gnz, ins, 0, 1, lat, {tag, "_t3"});
        end
        last_ir = ins;
    endtask

    // Pop planned cycles, drive their inputs and compare the DUT controls
    task automatic drain();
        entry_t e;
        int cyc;
        int done_cyc;
        cyc = 0;
        done_cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.first) begin
                cyc = 0;
                done_cyc = 0;
            end
            bus.run = e.run;
            bus.mem_ready = e.mrdy;
            bus.g_nz = e.gnz;
            bus.ir = e.ir;
            #1;
            cyc++;
            chk_word(e.tag, act, e.exp);
            if (act[1] && done_cyc == 0) done_cyc = cyc;
            if (e.last) chk_int({e.tag, "_latency"}, done_cyc, e.lat);
            @(negedge clock);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_ir = 9'b111_000_000;

        vecs[0] = '{"mv_r1_r0",    9'b000_001_000, 1'b0, 4, mk(8'h02, 8'h01, F_DONE), 28'h0, 28'h0};
        vecs[1] = '{"add_r1_r1",   9'b010_001_001, 1'b0, 6, mk(8'h00, 8'h02, F_AIN),
                    mk(8'h00, 8'h02, F_GIN), mk(8'h02, 8'h00, F_GOUT | F_DONE)};
        vecs[2] = '{"sub_r2_r0",   9'b011_010_000, 1'b0, 6, mk(8'h00, 8'h04, F_AIN),
                    mk(8'h00, 8'h01, F_GIN | F_ADDSUB), mk(8'h04, 8'h00, F_GOUT | F_DONE)};
        vecs[3] = '{"mvi_r5",      9'b001_101_000, 1'b0, 6, mk(8'h00, 8'h80, F_ADDR | F_INC),
                    28'h0, mk(8'h20, 8'h00, F_DIN | F_DONE)};
        vecs[4] = '{"ld_r3_r5",    9'b100_011_101, 1'b0, 6, mk(8'h00, 8'h20, F_ADDR),
                    28'h0, mk(8'h08, 8'h00, F_DIN | F_DONE)};
        vecs[5] = '{"st_r2_r6",    9'b101_010_110, 1'b0, 6, mk(8'h00, 8'h40, F_ADDR),
                    mk(8'h00, 8'h04, F_DOUT), mk(8'h00, 8'h00, F_WD | F_DONE)};
        vecs[6] = '{"mvnz_gnz0",   9'b110_100_110, 1'b0, 4, mk(8'h00, 8'h00, F_DONE), 28'h0, 28'h0};
        vecs[7] = '{"mvnz_gnz1",   9'b110_100_110, 1'b1, 4, mk(8'h10, 8'h40, F_DONE), 28'h0, 28'h0};
        vecs[8] = '{"nop",         9'b111_000_000, 1'b0, 4, mk(8'h00, 8'h00, F_DONE), 28'h0, 28'h0};
        vecs[9] = '{"mv_r7_r7",    9'b000_111_111, 1'b0, 4, mk(8'h80, 8'h80, F_DONE), 28'h0, 28'h0};

        reset = 1'b1;
        bus.run = 1'b1;
        bus.mem_ready = 1'b0;
        bus.g_nz = 1'b0;
        bus.ir = last_ir;

        @(negedge clock);
        #1 chk_word("reset_cycle1", act, 28'h0);
        @(negedge clock);
        #1 chk_word("reset_cycle2", act, 28'h0);
        reset = 1'b0;

        push(28'h0, 1'b1, 1'b0, 1'b0, last_ir, 0, 0, 0, "idle_after_reset");
        drain();

        foreach (vecs[i]) begin
            push_instr(vecs[i].tag, vecs[i].ins, vecs[i].gnz, 0, 0,
                       (vecs[i].lat == 4) ? 1 : 3,
                       vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].lat, 1'b1, 1'b1);
            drain();
        end

        // ld with three extra memory wait cycles in T2
        push_instr("ld_wait3", 9'b100_011_101, 1'b0, 0, 3, 3,
                   mk(8'h00, 8'h20, F_ADDR), 28'h0, mk(8'h08, 8'h00, F_DIN | F_DONE),
                   9, 1'b1, 1'b1);
        drain();

        // mvi with two fetch wait cycles, run low mid-instruction but high at done
        push_instr("mvi_runlow", 9'b001_011_000, 1'b0, 2, 0, 3,
                   mk(8'h00, 8'h80, F_ADDR | F_INC), 28'h0, mk(8'h08, 8'h00, F_DIN | F_DONE),
                   8, 1'b0, 1'b1);
        drain();

        // nop with run low at done: returns to IDLE, resumes only when run rises
        push_instr("nop_stop", 9'b111_000_000, 1'b0, 0, 0, 1,
                   mk(8'h00, 8'h00, F_DONE), 28'h0, 28'h0, 4, 1'b0, 1'b0);
        push(28'h0, 1'b0, 1'b0, 1'b0, last_ir, 0, 0, 0, "idle_hold");
        push(28'h0, 1'b1, 1'b0, 1'b0, last_ir, 0, 0, 0, "idle_restart");
        drain();

        // memory never ready: fifteen silent waits, then mem_err, then IDLE
        push(W_F0, 1'b0, 1'b0, 1'b0, last_ir, 0, 0, 0, "timeout_f0");
        for (int i = 0; i < 15; i++)
            push(28'h0, 1'b0, 1'b0, 1'b0, last_ir, 0, 0, 0, "timeout_wait");
        push(mk(8'h00, 8'h00, F_MERR), 1'b0, 1'b0, 1'b0, last_ir, 0, 0, 0, "timeout_mem_err");
        push(28'h0, 1'b0, 1'b0, 1'b0, last_ir, 0, 0, 0, "timeout_idle");
        push(28'h0, 1'b1, 1'b0, 1'b0, last_ir, 0, 0, 0, "timeout_idle_restart");
        drain();

        // reset asserted during T2 of add R1,R1
        push(W_F0, 1'b1, 1'b0, 1'b0, last_ir, 0, 0, 0, "rst_f0");
        push(28'h0, 1'b1, 1'b1, 1'b0, last_ir, 0, 0, 0, "rst_f1");
        push(W_F2, 1'b1, 1'b1, 1'b0, last_ir, 0, 0, 0, "rst_f2");
        push(mk(8'h00, 8'h02, F_AIN), 1'b1, 1'b1, 1'b0, 9'b010_001_001, 0, 0, 0, "rst_t1");
        drain();
        bus.ir = 9'b010_001_001;
        #1 chk_word("rst_t2_before", act, mk(8'h00, 8'h02, F_GIN));
        #1 reset = 1'b1;
        #1 chk_word("rst_async_outputs", act, 28'h0);
        @(negedge clock);
        #1 chk_word("rst_held", act, 28'h0);
        reset = 1'b0;
        last_ir = 9'b010_001_001;

        push(28'h0, 1'b1, 1'b0, 1'b0, last_ir, 0, 0, 0, "idle_after_rst");
        push_instr("mv_after_rst", 9'b000_001_000, 1'b0, 0, 0, 1,
                   mk(8'h02, 8'h01, F_DONE), 28'h0, 28'h0, 4, 1'b1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
